// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/write-back stage of the 3-stage RISC-V core.
//
// Captures the M-stage controls and datapath values into the W register,
// aligns and extends synchronous DMEM load data, runs the multi-cycle MMIO
// load handshake (stalling F/X/M while it waits) and drives the register
// file write port.
//
// Optional feature macro: MEM_WB_IO_TIMEOUT_EN
//   When defined, an IO_WAIT watchdog forces completion with 32'hDEAD_BEEF
//   after IO_TIMEOUT cycles without io_ack. When undefined, IO_WAIT waits
//   indefinitely and no counter exists.
//
// Ports:
//   clk, rst              core clock, synchronous active-high reset
//   valid_m .. pc4_m      M-stage instruction fields
//   dmem_dout             BRAM read data (valid the cycle after the address)
//   io_ack, io_rdata      MMIO read completion and data
//   io_req, io_addr       MMIO read request and address
//   rf_we, rf_wa, rf_wd   register-file write port
//   stall                 freeze F/X/M stages and the X->M register
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | W holds a non-IO instruction (or bubble); writes from W
// ST_IO_WAIT | MMIO load in W, io_req asserted, upstream stalled
// ST_IO_DONE | MMIO data in io_buf, written this cycle, pipeline moves

module mem_wb_stage #(
  parameter int unsigned IO_TIMEOUT = 255,
  parameter logic [3:0]  IO_REGION  = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        reg_we_m,
  input  logic [1:0]  wb_sel_m,
  input  logic [2:0]  funct3_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] alu_m,
  input  logic [31:0] pc4_m,
  input  logic [31:0] dmem_dout,
  input  logic        io_ack,
  input  logic [31:0] io_rdata,
  output logic        io_req,
  output logic [31:0] io_addr,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_IO_DONE = 2'd2
  } state_t;

  // A zero timeout would make IO_WAIT unreachable-yet-entered; reject it.
  if (IO_TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_wb_stage: IO_TIMEOUT must be at least 1");
  end

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        reg_we_q, reg_we_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] io_buf_q, io_buf_d;

  logic        capture;
  logic        m_is_io;
  logic [31:0] load_raw;

`ifdef MEM_WB_IO_TIMEOUT_EN
  localparam int unsigned CNT_W = (IO_TIMEOUT > 255) ? $clog2(IO_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(IO_TIMEOUT - 1);
  logic [CNT_W-1:0] io_cnt_q, io_cnt_d;
`endif

  function automatic logic [31:0] align(input logic [31:0] data,
                                        input logic [2:0]  f3,
                                        input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = data;
    endcase
    return r;
  endfunction

  // Next-state: W register, FSM, io_buf and optional watchdog.
  always_comb begin
    capture  = (state_q != ST_IO_WAIT);
    m_is_io  = valid_m && (wb_sel_m == 2'd0) && (alu_m[31:28] == IO_REGION);

    valid_d  = valid_q;
    reg_we_d = reg_we_q;
    wb_sel_d = wb_sel_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    alu_d    = alu_q;
    pc4_d    = pc4_q;
    state_d  = state_q;
    io_buf_d = io_buf_q;

    if (capture) begin
      valid_d  = valid_m;
      reg_we_d = reg_we_m;
      wb_sel_d = wb_sel_m;
      funct3_d = funct3_m;
      rd_d     = rd_m;
      alu_d    = alu_m;
      pc4_d    = pc4_m;
    end

    case (state_q)
      ST_IO_WAIT: begin
        if (io_ack) begin
          io_buf_d = io_rdata;
          state_d  = ST_IO_DONE;
        end
`ifdef MEM_WB_IO_TIMEOUT_EN
        else if (io_cnt_q == TO_LAST) begin
          io_buf_d = 32'hDEAD_BEEF;
          state_d  = ST_IO_DONE;
        end
`endif
      end
      default: begin
        // IDLE and IO_DONE both capture this cycle; the new W decides.
        state_d = m_is_io ? ST_IO_WAIT : ST_IDLE;
      end
    endcase

`ifdef MEM_WB_IO_TIMEOUT_EN
    // Held at zero outside IO_WAIT, so it reads 0 on the first wait cycle.
    io_cnt_d = (state_q == ST_IO_WAIT) ? io_cnt_q + CNT_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
      wb_sel_q <= 2'd1;
      funct3_q <= 3'd0;
      rd_q     <= 5'd0;
      alu_q    <= 32'd0;
      pc4_q    <= 32'd0;
      io_buf_q <= 32'd0;
`ifdef MEM_WB_IO_TIMEOUT_EN
      io_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      reg_we_q <= reg_we_d;
      wb_sel_q <= wb_sel_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      alu_q    <= alu_d;
      pc4_q    <= pc4_d;
      io_buf_q <= io_buf_d;
`ifdef MEM_WB_IO_TIMEOUT_EN
      io_cnt_q <= io_cnt_d;
`endif
    end
  end

  // Outputs are combinational from W and state.
  always_comb begin
    io_req   = (state_q == ST_IO_WAIT);
    stall    = io_req;
    io_addr  = io_req ? alu_q : 32'd0;
    rf_we    = valid_q && reg_we_q && (rd_q != 5'd0) && !io_req;
    rf_wa    = rd_q;
    load_raw = (state_q == ST_IO_DONE) ? io_buf_q : dmem_dout;
    case (wb_sel_q)
      2'd0:    rf_wd = align(load_raw, funct3_q, alu_q[1:0]);
      2'd2:    rf_wd = pc4_q;
      default: rf_wd = alu_q;
    endcase
  end

endmodule
